// File: rtl/temp_sample_seq.sv
// Periodic temperature sampling sequencer: requests a sensor reading, converts it to
// display nibbles with a serial double-dabble engine, and tracks alarm and timeout status.
module temp_sample_seq #(
   parameter int unsigned PERIOD  = 50_000_000,
   parameter int unsigned TIMEOUT = 60_000_000,
   parameter int unsigned ALM_HI  = 28,
   parameter int unsigned ALM_LO  = 26
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   output logic        conv_req,
   input  logic        drv_done,
   input  logic [15:0] drv_data,
   output logic [23:0] dis_data,
   output logic        dis_valid,
   output logic        en,
   output logic        err
);

   localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned BINW   = 21;
   localparam int unsigned BCDW   = 28;
   localparam int unsigned ITW    = 5;
   localparam int unsigned DEGW   = 7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      CALC = 3'd3,
      OUT  = 3'd4
   } state_t;

   state_t            state;
   logic [PW-1:0]     per_cnt;
   logic [TW-1:0]     to_cnt;
   logic [ITW-1:0]    it_cnt;
   logic              sign_q;
   logic [DEGW-1:0]   deg_q;
   logic [BINW-1:0]   shift_q;
   logic [BCDW-1:0]   bcd_q;
   logic [BCDW-1:0]   bcd_adj;
   logic              drv_unused;

   // Upper reading bits carry no information for this block.
   assign drv_unused = ^drv_data[15:12];

   // Add-3 correction applied to every BCD digit before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 7; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Sequencer: period timer, request/wait with timeout, serial conversion, output update.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         per_cnt   <= '0;   // zero so the first request follows reset release directly
         to_cnt    <= '0;
         it_cnt    <= '0;
         sign_q    <= 1'b0;
         deg_q     <= '0;
         shift_q   <= '0;
         bcd_q     <= '0;
         conv_req  <= 1'b0;
         dis_data  <= 24'hA00000;
         dis_valid <= 1'b0;
         en        <= 1'b0;
         err       <= 1'b0;
      end else begin
         conv_req  <= 1'b0;
         dis_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (per_cnt == '0) begin
                  per_cnt  <= PW'(PERIOD - 1);
                  conv_req <= 1'b1;
                  state    <= REQ;
               end else begin
                  per_cnt <= per_cnt - PW'(1);
               end
            end
            REQ: begin
               to_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               if (drv_done) begin
                  sign_q  <= drv_data[11];
                  deg_q   <= drv_data[10:4];
                  // Magnitude in 1e-4 degree units: 1/16 degC = 625e-4 degC.
                  shift_q <= BINW'(drv_data[10:0]) * BINW'(625);
                  bcd_q   <= '0;
                  it_cnt  <= '0;
                  state   <= CALC;
               end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            CALC: begin
               bcd_q   <= BCDW'({bcd_adj, shift_q[BINW-1]});
               shift_q <= {shift_q[BINW-2:0], 1'b0};
               it_cnt  <= it_cnt + ITW'(1);
               if (it_cnt == ITW'(BINW - 1)) begin
                  state <= OUT;
               end
            end
            OUT: begin
               dis_data  <= {(sign_q ? 4'hB : 4'hA), bcd_q[23:4]};
               dis_valid <= 1'b1;
               err       <= 1'b0;
               if (sign_q) begin
                  en <= 1'b0;
               end else if (deg_q >= DEGW'(ALM_HI)) begin
                  en <= 1'b1;
               end else if (deg_q < DEGW'(ALM_LO)) begin
                  en <= 1'b0;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
